// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   N-channel front end for the VGA framebuffer write port. Each producer channel
//   owns a small FIFO so write bursts are absorbed. A round-robin arbiter then
//   drains the FIFOs at one framebuffer write per clock.
//
//   Optional feature macro: VGA_ARB_OVF_CNT_EN
//     defined   -> per-channel 8-bit saturating dropped-write counters on ovf_cnt
//     undefined -> ovf_cnt is tied to zero and no counter logic is built
//
// Ports
//   clk        in   1            system clock
//   rstn       in   1            synchronous active-low reset
//   addr_in    in   N_CH*ADDR_W  channel k address at [k*ADDR_W +: ADDR_W]
//   dwrite_in  in   N_CH*DATA_W  channel k data at [k*DATA_W +: DATA_W]
//   wr_in      in   N_CH         channel k push request (one entry per high cycle)
//   full_out   out  N_CH         channel k FIFO full (registered)
//   addr       out  ADDR_W       framebuffer write address (registered)
//   dwrite     out  DATA_W       framebuffer write data (registered)
//   wr         out  1            framebuffer write strobe (registered)
//   grant_id   out  CH_W         channel that sourced the current addr/dwrite/wr
//   ovf_cnt    out  N_CH*8       per-channel dropped-write counters

// Per-channel FIFO. Push is refused while full and pop is refused while empty.
// Neither side bypasses the other, so an entry pushed at one edge becomes
// visible at the head no earlier than the next edge.
module vga_arb_fifo #(
  parameter int AW    = 19,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [AW+DW-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  // A push is gated by the registered full flag, so a pop in the same cycle
  // does not free room for that push.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  assign {o_addr, o_data} = r_mem[r_rd_ptr];

  // Storage has no reset. After reset the pointers make its stale contents unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_addr, i_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module vga_write_arbiter #(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH*ADDR_W-1:0] addr_in,
  input  logic [N_CH*DATA_W-1:0] dwrite_in,
  input  logic [N_CH-1:0]        wr_in,
  output logic [N_CH-1:0]        full_out,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      dwrite,
  output logic                   wr,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] grant_id,
  output logic [N_CH*8-1:0]      ovf_cnt
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0][ADDR_W-1:0] w_head_addr;
  logic [N_CH-1:0][DATA_W-1:0] w_head_data;
  logic [N_CH-1:0]             w_full;
  logic [N_CH-1:0]             w_empty;
  logic [N_CH-1:0]             w_pop;
  logic                        w_found;
  logic [CH_W-1:0]             w_sel;

  logic [CH_W-1:0]   r_rr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr;
  logic [CH_W-1:0]   r_gid;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    vga_arb_fifo #(
      .AW    (ADDR_W),
      .DW    (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (wr_in[k]),
      .i_pop   (w_pop[k]),
      .i_addr  (addr_in[k*ADDR_W +: ADDR_W]),
      .i_data  (dwrite_in[k*DATA_W +: DATA_W]),
      .o_addr  (w_head_addr[k]),
      .o_data  (w_head_data[k]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k])
    );
  end

  assign full_out = w_full;

  // Round-robin search. The search starts just after the last granted channel
  // and wraps, so the previous winner has the lowest priority.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    for (int i = 1; i <= N_CH; i++) begin
      v_idx = (int'(r_rr) + i) % N_CH;
      if (!w_found && !w_empty[v_idx]) begin
        w_found = 1'b1;
        w_sel   = CH_W'(v_idx);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < N_CH; k++) w_pop[k] = w_found && (w_sel == CH_W'(k));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr   <= CH_W'(N_CH - 1);
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
      r_gid  <= '0;
    end else begin
      r_wr <= w_found;
      // On idle cycles, address, data and grant keep the values of the last write.
      if (w_found) begin
        r_addr <= w_head_addr[w_sel];
        r_data <= w_head_data[w_sel];
        r_gid  <= w_sel;
        r_rr   <= w_sel;
      end
    end
  end

  assign addr     = r_addr;
  assign dwrite   = r_data;
  assign wr       = r_wr;
  assign grant_id = r_gid;

`ifdef VGA_ARB_OVF_CNT_EN
  logic [N_CH-1:0][7:0] r_ovf;

  // A drop is a push that arrives while the registered full flag is set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (wr_in[k] && w_full[k] && (r_ovf[k] != 8'hFF)) r_ovf[k] <= r_ovf[k] + 8'd1;
      end
    end
  end

  assign ovf_cnt = r_ovf;
`else
  assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;
  logic        clk;
  logic        rstn;
  logic [37:0] addr_in;
  logic [31:0] dwrite_in;
  logic [1:0]  wr_in;
  logic [1:0]  full_out;
  logic [18:0] addr;
  logic [15:0] dwrite;
  logic        wr;
  logic [0:0]  grant_id;
  logic [15:0] ovf_cnt;

  int errors = 0;
  int checks = 0;

`ifdef VGA_ARB_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  vga_write_arbiter #(.N_CH(2), .ADDR_W(19), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .addr_in   (addr_in),
    .dwrite_in (dwrite_in),
    .wr_in     (wr_in),
    .full_out  (full_out),
    .addr      (addr),
    .dwrite    (dwrite),
    .wr        (wr),
    .grant_id  (grant_id),
    .ovf_cnt   (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [1:0]  wr;
    logic [18:0] a0;
    logic [15:0] d0;
    logic [18:0] a1;
    logic [15:0] d1;
    logic        e_wr;
    logic [18:0] e_addr;
    logic [15:0] e_data;
    logic        e_gid;
    logic [1:0]  e_full;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic [1:0] w, logic [18:0] a0, logic [15:0] d0,
                              logic [18:0] a1, logic [15:0] d1, logic ew, logic [18:0] ea,
                              logic [15:0] ed, logic eg, logic [1:0] ef);
    vec_t v;
    v.rstn = r; v.wr = w; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_gid = eg; v.e_full = ef;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic [1:0] w, input logic [18:0] a0,
                      input logic [15:0] d0, input logic [18:0] a1, input logic [15:0] d1);
    rstn = r; wr_in = w;
    addr_in = {a1, a0}; dwrite_in = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  // Expected output of the overflow burst at edge e: -1 means idle,
  // otherwise ch*16+idx. A6, B7, A8 and B9 are dropped and must never appear.
  int exp_tag [18] = '{-1, 16, 0, 17, 1, 18, 2, 19, 3, 20, 4, 21, 5, 22, 7, 24, 9, -1};

  initial begin
    rstn = 1'b0; wr_in = '0; addr_in = '0; dwrite_in = '0;

    // Reset with all pushes requested, release, then round-robin A0,B0,.. then latency.
    tbl[0]  = mk(0, 2'b11, 19'h1, 16'h1, 19'h2, 16'h2, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[1]  = mk(0, 2'b11, 19'h1, 16'h1, 19'h2, 16'h2, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[2]  = mk(0, 2'b11, 19'h1, 16'h1, 19'h2, 16'h2, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[3]  = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[4]  = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[5]  = mk(1, 2'b11, 19'h10, 16'hA000, 19'h20, 16'hB000, 0, 19'h0, 16'h0, 0, 2'b00);
    tbl[6]  = mk(1, 2'b11, 19'h11, 16'hA001, 19'h21, 16'hB001, 1, 19'h10, 16'hA000, 0, 2'b00);
    tbl[7]  = mk(1, 2'b11, 19'h12, 16'hA002, 19'h22, 16'hB002, 1, 19'h20, 16'hB000, 1, 2'b00);
    tbl[8]  = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 1, 19'h11, 16'hA001, 0, 2'b00);
    tbl[9]  = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 1, 19'h21, 16'hB001, 1, 2'b00);
    tbl[10] = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 1, 19'h12, 16'hA002, 0, 2'b00);
    tbl[11] = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 1, 19'h22, 16'hB002, 1, 2'b00);
    tbl[12] = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 0, 19'h22, 16'hB002, 1, 2'b00);
    tbl[13] = mk(1, 2'b01, 19'h00123, 16'hABCD, 19'h0, 16'h0, 0, 19'h22, 16'hB002, 1, 2'b00);
    tbl[14] = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 1, 19'h00123, 16'hABCD, 0, 2'b00);
    tbl[15] = mk(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0, 0, 19'h00123, 16'hABCD, 0, 2'b00);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rstn, tbl[i].wr, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      check($sformatf("vec%0d.wr", i), 32'(wr), 32'(tbl[i].e_wr));
      check($sformatf("vec%0d.addr", i), 32'(addr), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d.dwrite", i), 32'(dwrite), 32'(tbl[i].e_data));
      check($sformatf("vec%0d.grant", i), 32'(grant_id), 32'(tbl[i].e_gid));
      check($sformatf("vec%0d.full", i), 32'(full_out), 32'(tbl[i].e_full));
      check($sformatf("vec%0d.ovf", i), 32'(ovf_cnt), 32'h0);
    end

    // Overflow burst: both channels push 10 entries back-to-back. Edge 6 also
    // covers full+pop in the same cycle: ch0 is full, popped, and its push is dropped.
    for (int e = 0; e < 18; e++) begin
      if (e < 10) step(1, 2'b11, 19'h100 + 19'(e), 16'hA100 + 16'(e), 19'h200 + 19'(e), 16'hB100 + 16'(e));
      else        step(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0);
      if (exp_tag[e] < 0) begin
        check($sformatf("ovf_e%0d.wr", e), 32'(wr), 32'h0);
      end else begin
        check($sformatf("ovf_e%0d.wr", e), 32'(wr), 32'h1);
        check($sformatf("ovf_e%0d.grant", e), 32'(grant_id), 32'(exp_tag[e] / 16));
        check($sformatf("ovf_e%0d.addr", e), 32'(addr),
              (exp_tag[e] >= 16) ? 32'h200 + 32'(exp_tag[e] % 16) : 32'h100 + 32'(exp_tag[e] % 16));
        check($sformatf("ovf_e%0d.dwrite", e), 32'(dwrite),
              (exp_tag[e] >= 16) ? 32'hB100 + 32'(exp_tag[e] % 16) : 32'hA100 + 32'(exp_tag[e] % 16));
      end
      if (e == 5) check("ovf_e5.full", 32'(full_out), 32'h1);
      if (e == 6) begin
        check("ovf_e6.full", 32'(full_out), 32'h2);
        check("ovf_e6.ovf", 32'(ovf_cnt), OVF_EN ? 32'h0001 : 32'h0);
      end
    end
    check("ovf_end.full", 32'(full_out), 32'h0);
    check("ovf_end.ovf", 32'(ovf_cnt), OVF_EN ? 32'h0202 : 32'h0);

    // Reset mid-burst: queue entries on both channels, reset, and expect nothing to drain.
    step(1, 2'b11, 19'h300, 16'hC000, 19'h380, 16'hD000);
    check("rmb.f0.wr", 32'(wr), 32'h0);
    step(1, 2'b11, 19'h301, 16'hC001, 19'h381, 16'hD001);
    check("rmb.f1.wr", 32'(wr), 32'h1);
    check("rmb.f1.addr", 32'(addr), 32'h380);
    step(1, 2'b11, 19'h302, 16'hC002, 19'h382, 16'hD002);
    check("rmb.f2.addr", 32'(addr), 32'h300);
    check("rmb.f2.grant", 32'(grant_id), 32'h0);
    step(0, 2'b11, 19'h3AA, 16'hEEEE, 19'h3BB, 16'hFFFF);
    check("rmb.rst.wr", 32'(wr), 32'h0);
    check("rmb.rst.addr", 32'(addr), 32'h0);
    check("rmb.rst.dwrite", 32'(dwrite), 32'h0);
    check("rmb.rst.full", 32'(full_out), 32'h0);
    check("rmb.rst.ovf", 32'(ovf_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0);
      check($sformatf("rmb.idle%0d.wr", i), 32'(wr), 32'h0);
    end
    step(1, 2'b01, 19'h3FF, 16'h5A5A, 19'h0, 16'h0);
    check("rmb.push.wr", 32'(wr), 32'h0);
    step(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0);
    check("rmb.out.wr", 32'(wr), 32'h1);
    check("rmb.out.addr", 32'(addr), 32'h3FF);
    check("rmb.out.dwrite", 32'(dwrite), 32'h5A5A);
    check("rmb.out.grant", 32'(grant_id), 32'h0);
    step(1, 2'b00, 19'h0, 16'h0, 19'h0, 16'h0);
    check("rmb.after.wr", 32'(wr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
